// File: rtl/draw_pkg.sv
// Shared rasteriser types: the line FSM state encoding and the default coordinate type.
// render_* sequencers reuse draw_state_t so their state decoding stays aligned.
package draw_pkg;

  localparam int unsigned CORDW_DEFAULT = 16;

  typedef logic signed [CORDW_DEFAULT-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DRAW,
    DONE
  } draw_state_t;

endpackage

// File: rtl/draw_line_if.sv
// Command/pixel bundle between a render sequencer (master) and draw_line (slave).
// Defining DRAW_LINE_CLIP_EN adds the clip_w/clip_h window inputs.
interface draw_line_if #(
  parameter int unsigned CORDW = 16
);

  logic                    start;
  logic                    oe;
  logic signed [CORDW-1:0] x0;
  logic signed [CORDW-1:0] y0;
  logic signed [CORDW-1:0] x1;
  logic signed [CORDW-1:0] y1;
  logic signed [CORDW-1:0] x;
  logic signed [CORDW-1:0] y;
  logic                    drawing;
  logic                    busy;
  logic                    done;
`ifdef DRAW_LINE_CLIP_EN
  logic        [CORDW-1:0] clip_w;
  logic        [CORDW-1:0] clip_h;
`endif

  modport master (
    output start, oe, x0, y0, x1, y1,
`ifdef DRAW_LINE_CLIP_EN
    output clip_w, clip_h,
`endif
    input  x, y, drawing, busy, done
  );

  modport slave (
    input  start, oe, x0, y0, x1, y1,
`ifdef DRAW_LINE_CLIP_EN
    input  clip_w, clip_h,
`endif
    output x, y, drawing, busy, done
  );

endinterface

// File: rtl/draw_line.sv
// Bresenham line rasteriser: one pixel per oe cycle over all octants.
// Defining DRAW_LINE_CLIP_EN masks drawing to the window [0,clip_w) x [0,clip_h).
module draw_line
  import draw_pkg::*;
#(
  parameter int unsigned CORDW = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  draw_line_if.slave  bus
);

  draw_state_t             state_q;
  logic signed [CORDW-1:0] xa_q, ya_q, xb_q, yb_q;
  logic signed [CORDW-1:0] x_q, y_q;
  logic signed [CORDW:0]   dx_q, dy_q;
  logic signed [CORDW+1:0] err_q;
  logic                    sx_neg_q, sy_neg_q;
  logic                    busy_q, done_q;

  // Endpoint deltas are formed one bit wider so full-range endpoints cannot overflow.
  logic signed [CORDW:0]   xa_e, ya_e, xb_e, yb_e, dxs, dys, dx_c, dy_c;
  logic signed [CORDW+1:0] err_init, err_next, dx_e, dy_e;
  logic signed [CORDW+2:0] e2, dx_w, dy_w;
  logic signed [CORDW-1:0] x_step, y_step;
  logic                    step_x, step_y, at_end;

  always_comb begin
    xa_e     = {xa_q[CORDW-1], xa_q};
    ya_e     = {ya_q[CORDW-1], ya_q};
    xb_e     = {xb_q[CORDW-1], xb_q};
    yb_e     = {yb_q[CORDW-1], yb_q};
    dxs      = xb_e - xa_e;
    dys      = yb_e - ya_e;
    dx_c     = dxs[CORDW] ? -dxs : dxs;
    dy_c     = dys[CORDW] ? dys : -dys;
    err_init = {dx_c[CORDW], dx_c} + {dy_c[CORDW], dy_c};
  end

  always_comb begin
    e2       = {err_q, 1'b0};
    dx_w     = {{2{dx_q[CORDW]}}, dx_q};
    dy_w     = {{2{dy_q[CORDW]}}, dy_q};
    dx_e     = {dx_q[CORDW], dx_q};
    dy_e     = {dy_q[CORDW], dy_q};
    step_x   = (e2 >= dy_w);
    step_y   = (e2 <= dx_w);
    // Both tests use the pre-update error term, so diagonal steps add dx and dy together.
    err_next = err_q + (step_x ? dy_e : '0) + (step_y ? dx_e : '0);
    x_step   = sx_neg_q ? {CORDW{1'b1}} : CORDW'(1);
    y_step   = sy_neg_q ? {CORDW{1'b1}} : CORDW'(1);
    at_end   = (x_q == xb_q) && (y_q == yb_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      xa_q     <= '0;
      ya_q     <= '0;
      xb_q     <= '0;
      yb_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      err_q    <= '0;
      sx_neg_q <= 1'b0;
      sy_neg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            xa_q    <= bus.x0;
            ya_q    <= bus.y0;
            xb_q    <= bus.x1;
            yb_q    <= bus.y1;
            busy_q  <= 1'b1;
            state_q <= INIT;
          end
        end
        INIT: begin
          dx_q     <= dx_c;
          dy_q     <= dy_c;
          err_q    <= err_init;
          sx_neg_q <= !(xa_q < xb_q);
          sy_neg_q <= !(ya_q < yb_q);
          x_q      <= xa_q;
          y_q      <= ya_q;
          state_q  <= DRAW;
        end
        DRAW: begin
          if (bus.oe) begin
            if (at_end) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q <= err_next;
              if (step_x) x_q <= x_q + x_step;
              if (step_y) y_q <= y_q + y_step;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DRAW_LINE_CLIP_EN
  logic in_clip;
  assign in_clip = !x_q[CORDW-1] && ($unsigned(x_q) < bus.clip_w) &&
                   !y_q[CORDW-1] && ($unsigned(y_q) < bus.clip_h);
  assign bus.drawing = bus.oe && (state_q == DRAW) && in_clip;
`else
  assign bus.drawing = bus.oe && (state_q == DRAW);
`endif

  assign bus.x    = x_q;
  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
